// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates cfg_len MAC beats per psum, narrows each sum and buffers it in a FIFO.
// Define PSUM_SAT_EN to make the accumulator and the narrowing saturate; by default both wrap.
module psum_accumulator #(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 32,
  parameter int LEN_W        = 8,
  parameter int OUT_SHIFT    = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic [LEN_W-1:0]        cfg_num,
  input  logic [OUT_BITWIDTH-1:0] mac_out,
  input  logic                    mac_valid,
  output logic                    mac_ready,
  output logic [IN_BITWIDTH-1:0]  psum_out,
  output logic                    psum_valid,
  input  logic                    psum_ready,
  output logic                    busy,
  output logic                    done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_next;
  logic [LEN_W-1:0] len_q, num_q, beat_cnt, psum_cnt;
  logic [OUT_BITWIDTH-1:0] acc, acc_next;
  logic [IN_BITWIDTH-1:0] psum_n;
  logic [IN_BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic done_zero, launch, accept, last_beat, last_psum, push, pop, full;

  assign launch     = state == IDLE && start && cfg_num != '0;
  assign full       = count == (AW+1)'(FIFO_DEPTH);
  assign mac_ready  = state == ACCUM && !full;
  assign accept     = mac_valid && mac_ready;
  assign last_beat  = beat_cnt == len_q - LEN_W'(1);
  assign last_psum  = psum_cnt == num_q - LEN_W'(1);
  assign push       = accept && last_beat;
  assign psum_valid = count != '0;
  assign pop        = psum_ready && psum_valid;
  assign psum_out   = psum_valid ? mem[rd_ptr] : '0;
  assign busy       = state == ACCUM;
  assign done       = done_zero || (push && last_psum);

`ifdef PSUM_SAT_EN
  logic [OUT_BITWIDTH:0] sum;
  logic [OUT_BITWIDTH-1:0] v;
  assign sum      = {1'b0, acc} + {1'b0, mac_out};
  assign acc_next = sum[OUT_BITWIDTH] ? '1 : sum[OUT_BITWIDTH-1:0];
  assign v        = acc_next >> OUT_SHIFT;
  assign psum_n   = (v >> IN_BITWIDTH) != '0 ? '1 : v[IN_BITWIDTH-1:0];
`else
  assign acc_next = acc + mac_out;
  assign psum_n   = IN_BITWIDTH'(acc_next >> OUT_SHIFT);
`endif

  always_comb begin
    state_next = state;
    state_next = launch ? ACCUM : (push && last_psum) ? IDLE : state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      num_q     <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
      psum_cnt  <= '0;
      done_zero <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      done_zero <= state == IDLE && start && cfg_num == '0;
      if (launch) begin
        len_q    <= cfg_len == '0 ? LEN_W'(1) : cfg_len;
        num_q    <= cfg_num;
        acc      <= '0;
        beat_cnt <= '0;
        psum_cnt <= '0;
      end else if (accept) begin
        acc      <= last_beat ? '0 : acc_next;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        psum_cnt <= last_beat ? psum_cnt + 1'b1 : psum_cnt;
      end
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // storage is not reset: count gates visibility of stale entries
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= psum_n;
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed jobs with a psum scoreboard checked by an independent output monitor.
module tb_psum_accumulator;
  logic clk = 0, reset = 0, start = 0, mac_valid = 0, psum_ready = 0;
  logic [7:0] cfg_len = 0, cfg_num = 0;
  logic [31:0] mac_out = 0;
  logic mac_ready, psum_valid, busy, done;
  logic [15:0] psum_out;
  int total = 0, bad = 0, done_cnt = 0, d0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
    .mac_out(mac_out), .mac_valid(mac_valid), .mac_ready(mac_ready),
    .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (psum_valid && psum_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_psum: got %0d expected none", psum_out);
      end else check("psum", {16'b0, psum_out}, {16'b0, exp_q.pop_front()});
    end
  end

  task automatic start_job(input logic [7:0] len, input logic [7:0] num);
    start = 1; cfg_len = len; cfg_num = num;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic beat(input logic [31:0] v);
    int n = 0;
    mac_out = v; mac_valid = 1;
    @(negedge clk);
    while (!mac_ready && n < 200) begin n++; @(negedge clk); end
    if (!mac_ready) check("beat_timeout", {31'b0, mac_ready}, 1);
    @(posedge clk); #1;
    mac_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin n++; @(posedge clk); end
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mac_ready", {31'b0, mac_ready}, 0);
    check("rst_psum_valid", {31'b0, psum_valid}, 0);
    check("rst_psum_out", {16'b0, psum_out}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    reset = 1; psum_ready = 1;
    @(posedge clk); #1;
    // single beat
    d0 = done_cnt;
    start_job(1, 1);
    check("t1_busy", {31'b0, busy}, 1);
    exp_q.push_back(16'd65000);
    beat(65000);
    check("t1_lat_valid", {31'b0, psum_valid}, 1);
    check("t1_lat_out", {16'b0, psum_out}, 65000);
    check("t1_busy_fall", {31'b0, busy}, 0);
    check("t1_done", done_cnt, d0 + 1);
    drain();
    // narrowed overflow
    start_job(2, 1);
`ifdef PSUM_SAT_EN
    exp_q.push_back(16'd65535);
`else
    exp_q.push_back(16'd64464);
`endif
    beat(65000); beat(65000);
    drain();
    // multi-psum job
    d0 = done_cnt;
    start_job(3, 2);
    exp_q.push_back(16'd42015); exp_q.push_back(16'd28003);
    beat(42000); beat(0); beat(15);
    check("t3_no_done_first", done_cnt, d0);
    beat(28000); beat(1); beat(2);
    check("t3_done_second", done_cnt, d0 + 1);
    drain();
    // backpressure
    psum_ready = 0;
    start_job(1, 6);
    for (int i = 1; i <= 6; i++) exp_q.push_back(16'(i * 100));
    for (int i = 1; i <= 4; i++) beat(32'(i * 100));
    mac_out = 500; mac_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_mac_ready", {31'b0, mac_ready}, 0);
    check("bp_psum_valid", {31'b0, psum_valid}, 1);
    check("bp_busy", {31'b0, busy}, 1);
    psum_ready = 1;
    beat(500); beat(600);
    drain();
    check("bp_busy_end", {31'b0, busy}, 0);
    // cfg_len = 0 acts as 1
    d0 = done_cnt;
    start_job(0, 1);
    exp_q.push_back(16'd777);
    beat(777);
    check("len0_done", done_cnt, d0 + 1);
    drain();
    // cfg_num = 0 completes immediately
    d0 = done_cnt;
    start_job(5, 0);
    check("num0_busy", {31'b0, busy}, 0);
    check("num0_done", {31'b0, done}, 1);
    repeat (3) @(posedge clk);
    #1;
    check("num0_done_once", done_cnt, d0 + 1);
    check("num0_no_psum", {31'b0, psum_valid}, 0);
    // start during ACCUM is ignored
    d0 = done_cnt;
    start_job(2, 2);
    start_job(1, 5);
    exp_q.push_back(16'd30); exp_q.push_back(16'd70);
    beat(10); beat(20); beat(30); beat(40);
    check("ign_busy", {31'b0, busy}, 0);
    check("ign_done", done_cnt, d0 + 1);
    drain();
    // reset mid-job with one psum buffered
    psum_ready = 0;
    start_job(3, 2);
    beat(1); beat(2); beat(3); beat(100); beat(200);
    check("mid_buffered", {31'b0, psum_valid}, 1);
    reset = 0;
    #1;
    check("mid_rst_mac_ready", {31'b0, mac_ready}, 0);
    check("mid_rst_psum_valid", {31'b0, psum_valid}, 0);
    check("mid_rst_psum_out", {16'b0, psum_out}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_done", {31'b0, done}, 0);
    @(posedge clk); #1;
    reset = 1; psum_ready = 1;
    d0 = done_cnt;
    start_job(2, 1);
    exp_q.push_back(16'd11);
    beat(5); beat(6);
    drain();
    check("post_rst_done", done_cnt, d0 + 1);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Consumes the 32-bit unsigned MAC result stream and accumulates beats over a configured filter length.
- Narrows each accumulated sum to an IN_BITWIDTH partial sum and buffers it for the PE's psum output path.
- Sits downstream of MAC inside the PE and is the reader of MAC.out.
- Runs one job, started by a start pulse, that produces cfg_num psums.

Parameters:
- IN_BITWIDTH, 16, width of each emitted psum.
- OUT_BITWIDTH, 32, width of the MAC result and the accumulator.
- LEN_W, 8, width of cfg_len and cfg_num.
- OUT_SHIFT, 0, right shift applied to the accumulator before narrowing; legal range 0..OUT_BITWIDTH-IN_BITWIDTH.
- FIFO_DEPTH, 4, depth of the output psum FIFO; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches cfg_len and cfg_num. Honoured only in IDLE.
- cfg_len  in  LEN_W  number of MAC beats per psum; 0 is treated as 1.
- cfg_num  in  LEN_W  number of psums in the job; 0 means the job completes immediately.
- mac_out  in  OUT_BITWIDTH  MAC result beat.
- mac_valid  in  1  mac_out is valid.
- mac_ready  out  1  accumulator accepts a beat.
- psum_out  out  IN_BITWIDTH  head of the FIFO.
- psum_valid  out  1  FIFO is not empty.
- psum_ready  in  1  downstream pops the FIFO head.
- busy  out  1  state is ACCUM.
- done  out  1  one-cycle pulse when the final psum of the job is pushed.

Behaviour:
- Reset values (async assert, reset low): state IDLE, acc 0, beat_cnt 0, psum_cnt 0, FIFO empty.
  - Outputs: mac_ready 0, psum_valid 0, psum_out 0, busy 0, done 0.
- States: IDLE, ACCUM.
- IDLE to ACCUM: on start with cfg_num != 0.
  - len_q = max(cfg_len, 1); num_q = cfg_num; acc, beat_cnt and psum_cnt are cleared.
- IDLE with start and cfg_num == 0: stay in IDLE and pulse done the next cycle.
- start while in ACCUM is ignored.
- mac_ready = (state == ACCUM) && !fifo_full. This is a combinational function of registered state only.
- A beat is accepted when mac_valid && mac_ready.
  - acc_next = acc + mac_out, computed in OUT_BITWIDTH+1 bits. The overflow rule is given under Optional Feature.
- On an accepted beat with beat_cnt == len_q-1:
  - The narrowed acc_next is pushed into the FIFO.
  - acc and beat_cnt are cleared; psum_cnt increments.
  - Otherwise beat_cnt increments and acc = acc_next.
- Last psum of the job (psum_cnt == num_q-1 on that push): done pulses in the same cycle as the push; the next state is IDLE.
- Narrowing: v = acc_next >> OUT_SHIFT; psum = v[IN_BITWIDTH-1:0], or saturated per Optional Feature.
- Latency: the psum appears on psum_out with psum_valid high in the cycle after the accepting edge of its last beat.
- FIFO:
  - Standard circular buffer with wrap-around pointers and an occupancy count.
  - Push and pop in the same cycle are legal when the FIFO is not empty; occupancy is then unchanged.
  - A push into a full FIFO cannot occur, because mac_ready is low.
  - A pop of an empty FIFO is ignored.
  - The FIFO drains independently of state, so psums remain poppable after the return to IDLE.
- psum_out holds its value while psum_valid && !psum_ready.
- Reset asserted mid-job discards acc, the counters and all FIFO contents immediately.

Optional Feature:
- Macro: PSUM_SAT_EN
- Defined:
  - The accumulator saturates at 2^OUT_BITWIDTH-1 instead of wrapping.
  - Narrowing saturates: if v > 2^IN_BITWIDTH-1, psum = 2^IN_BITWIDTH-1.
- Undefined:
  - The accumulator wraps modulo 2^OUT_BITWIDTH.
  - Narrowing truncates to the low IN_BITWIDTH bits of v.

Test Plan:
- Single beat: start, cfg_len=1, cfg_num=1, mac_out=65000 (1*61000+4000), psum_ready=1.
  - psum_out=65000 one cycle after acceptance; done pulses; busy falls.
- Overflow of the narrowed value: cfg_len=2, cfg_num=1, beats 65000, 65000.
  - PSUM_SAT_EN defined: psum_out=65535.
  - PSUM_SAT_EN undefined: psum_out=64464.
- Multi-psum job: cfg_len=3, cfg_num=2, beats 42000, 0, 15 and then 28000, 1, 2.
  - psum_out=42015, then 28003; done pulses only on the second push.
- Backpressure: cfg_len=1, cfg_num=6, psum_ready=0, mac_valid=1.
  - Exactly 4 psums are buffered and mac_ready drops to 0.
  - After raising psum_ready, all 6 psums drain in order.
- Degenerate and illegal controls:
  - cfg_len=0 behaves as length 1.
  - cfg_num=0 gives done with no psums produced.
  - A start pulse during ACCUM leaves len_q and num_q unchanged.
- Reset mid-job: reset low after 2 of 3 beats, with 1 psum in the FIFO.
  - All outputs return to their reset values immediately (psum_valid=0).
  - A new job after reset is unaffected by the earlier partial accumulation.
